// File: rtl/mul_bus_top.sv
// Bus-attached subsystem: 32-word scratch RAM plus a 64x64 unsigned shift-add
// multiplier with register interface and done interrupts, behind one master.
module mul_bus_top #(
    parameter int MUL_BITS  = 64,
    parameter int RAM_DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        M_req,
    input  logic        M_wr,
    input  logic [7:0]  M_address,
    input  logic [31:0] M_dout,
    output logic        M_grant,
    output logic [31:0] M_din,
    output logic        f_interrupt,
    output logic        m_interrupt
);

    localparam int RAM_AW    = $clog2(RAM_DEPTH);
    localparam int CNT_W     = $clog2(MUL_BITS) + 1;
    localparam int PROD_BITS = 2 * MUL_BITS;

    localparam logic [7:0] ADDR_A_LO   = 8'h40;
    localparam logic [7:0] ADDR_A_HI   = 8'h41;
    localparam logic [7:0] ADDR_B_LO   = 8'h42;
    localparam logic [7:0] ADDR_B_HI   = 8'h43;
    localparam logic [7:0] ADDR_RES0   = 8'h44;
    localparam logic [7:0] ADDR_RES1   = 8'h45;
    localparam logic [7:0] ADDR_RES2   = 8'h46;
    localparam logic [7:0] ADDR_RES3   = 8'h47;
    localparam logic [7:0] ADDR_CTRL   = 8'h48;
    localparam logic [7:0] ADDR_ABORT  = 8'h49;
    localparam logic [7:0] ADDR_INTEN  = 8'h4A;
    localparam logic [7:0] ADDR_CLRDN  = 8'h4B;

    logic                 r_grant;
    logic [31:0]          r_ram [RAM_DEPTH];
    logic [MUL_BITS-1:0]  r_opA;
    logic [MUL_BITS-1:0]  r_opB;
    logic                 r_intEn;
    logic [PROD_BITS-1:0] r_mcand;
    logic [MUL_BITS-1:0]  r_mplier;
    logic [PROD_BITS-1:0] r_acc;
    logic [CNT_W-1:0]     r_count;
    logic [PROD_BITS-1:0] r_result;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_xfer;
    logic                 w_wrEn;
    logic                 w_ramSel;
    logic                 w_start;
    logic                 w_abort;
    logic                 w_clrDone;
    logic                 w_lastBit;
    logic [PROD_BITS-1:0] w_addend;
    logic [PROD_BITS-1:0] w_accNext;
    logic [31:0]          w_rdata;

    assign w_xfer    = r_grant & M_req;
    assign w_wrEn    = w_xfer & M_wr;
    assign w_ramSel  = (M_address < 8'(RAM_DEPTH));
    assign w_start   = w_wrEn && (M_address == ADDR_CTRL)  && M_dout[0];
    assign w_abort   = w_wrEn && (M_address == ADDR_ABORT) && M_dout[0];
    assign w_clrDone = w_wrEn && (M_address == ADDR_CLRDN) && M_dout[0];

    assign w_lastBit = r_busy && (r_count == CNT_W'(MUL_BITS - 1));
    assign w_addend  = r_mplier[0] ? r_mcand : '0;
    assign w_accNext = r_acc + w_addend;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_grant <= 1'b0;
        end else begin
            r_grant <= M_req;
        end
    end

    // RAM contents survive reset; only the bus write path touches them.
    always_ff @(posedge clk) begin
        if (w_wrEn && w_ramSel) begin
            r_ram[M_address[RAM_AW-1:0]] <= M_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_opA   <= '0;
            r_opB   <= '0;
            r_intEn <= 1'b0;
        end else if (w_wrEn) begin
            case (M_address)
                ADDR_A_LO:  r_opA[31:0]          <= M_dout;
                ADDR_A_HI:  r_opA[MUL_BITS-1:32] <= M_dout;
                ADDR_B_LO:  r_opB[31:0]          <= M_dout;
                ADDR_B_HI:  r_opB[MUL_BITS-1:32] <= M_dout;
                ADDR_INTEN: r_intEn              <= M_dout[0];
                default: ;
            endcase
        end
    end

    // Completion is checked first so it wins over a clear or abort on the same edge.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (w_lastBit) begin
            r_result <= w_accNext;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
        end else if (w_abort) begin
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (w_start && !r_busy) begin
            r_mcand  <= {{MUL_BITS{1'b0}}, r_opA};
            r_mplier <= r_opB;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            if (r_busy) begin
                r_acc    <= w_accNext;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_count  <= r_count + CNT_W'(1);
            end
            if (w_clrDone) begin
                r_done <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_ramSel) begin
            w_rdata = r_ram[M_address[RAM_AW-1:0]];
        end else begin
            case (M_address)
                ADDR_A_LO:  w_rdata = r_opA[31:0];
                ADDR_A_HI:  w_rdata = r_opA[MUL_BITS-1:32];
                ADDR_B_LO:  w_rdata = r_opB[31:0];
                ADDR_B_HI:  w_rdata = r_opB[MUL_BITS-1:32];
                ADDR_RES0:  w_rdata = r_result[31:0];
                ADDR_RES1:  w_rdata = r_result[63:32];
                ADDR_RES2:  w_rdata = r_result[95:64];
                ADDR_RES3:  w_rdata = r_result[127:96];
                ADDR_CTRL:  w_rdata = {30'b0, r_done, r_busy};
                ADDR_INTEN: w_rdata = {31'b0, r_intEn};
                default:    w_rdata = '0;
            endcase
        end
    end

    assign M_grant     = r_grant;
    assign M_din       = (r_grant && !M_wr) ? w_rdata : 32'h0;
    assign f_interrupt = r_done;
    assign m_interrupt = r_done & r_intEn;

endmodule

// File: tb/tb_mul_bus_top.sv
// Randomised bench for mul_bus_top: bus transactions are mirrored into a
// transaction-level model (word arrays, 128-bit product, completion cycle).
module tb_mul_bus_top;

    localparam int MUL_BITS = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        M_req;
    logic        M_wr;
    logic [7:0]  M_address;
    logic [31:0] M_dout;
    logic        M_grant;
    logic [31:0] M_din;
    logic        f_interrupt;
    logic        m_interrupt;

    mul_bus_top #(.MUL_BITS(64), .RAM_DEPTH(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .M_req       (M_req),
        .M_wr        (M_wr),
        .M_address   (M_address),
        .M_dout      (M_dout),
        .M_grant     (M_grant),
        .M_din       (M_din),
        .f_interrupt (f_interrupt),
        .m_interrupt (m_interrupt)
    );

    always #5 clk = ~clk;

    int cycleCount = 0;
    always @(posedge clk) cycleCount <= cycleCount + 1;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0]  modelRam [32];
    logic [63:0]  modelA;
    logic [63:0]  modelB;
    logic [127:0] modelResult;
    logic [127:0] modelProduct;
    bit           modelRunning;
    bit           modelDone;
    bit           modelIntEn;
    int           modelEndCycle;
    int           modelDoneEdge;
    bit           reqOn;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // A run started on edge e finishes on edge e+MUL_BITS.
    function automatic void modelSync(input int c);
        if (modelRunning && c >= modelEndCycle) begin
            modelRunning  = 1'b0;
            modelDone     = 1'b1;
            modelResult   = modelProduct;
            modelDoneEdge = modelEndCycle;
        end
    endfunction

    function automatic void modelReset();
        modelA        = '0;
        modelB        = '0;
        modelResult   = '0;
        modelProduct  = '0;
        modelRunning  = 1'b0;
        modelDone     = 1'b0;
        modelIntEn    = 1'b0;
        modelEndCycle = 0;
        modelDoneEdge = -1;
    endfunction

    function automatic logic [31:0] expectedRead(input logic [7:0] addr);
        if (addr < 8'd32) return modelRam[addr[4:0]];
        case (addr)
            8'h40:   return modelA[31:0];
            8'h41:   return modelA[63:32];
            8'h42:   return modelB[31:0];
            8'h43:   return modelB[63:32];
            8'h44:   return modelResult[31:0];
            8'h45:   return modelResult[63:32];
            8'h46:   return modelResult[95:64];
            8'h47:   return modelResult[127:96];
            8'h48:   return {30'b0, modelDone, modelRunning};
            8'h4A:   return {31'b0, modelIntEn};
            default: return 32'h0;
        endcase
    endfunction

    task automatic ensureGrant();
        if (!reqOn) begin
            M_req = 1'b1;
            @(negedge clk);
            reqOn = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] addr, input logic [31:0] data);
        int e;
        bit wasBusy;
        ensureGrant();
        M_wr      = 1'b1;
        M_address = addr;
        M_dout    = data;
        @(posedge clk);
        @(negedge clk);
        e         = cycleCount;
        M_wr      = 1'b0;
        M_address = 8'h30;
        M_dout    = 32'h0;
        wasBusy   = modelRunning && (modelEndCycle >= e);
        modelSync(e);
        if (addr < 8'd32) begin
            modelRam[addr[4:0]] = data;
        end else begin
            case (addr)
                8'h40: modelA[31:0]  = data;
                8'h41: modelA[63:32] = data;
                8'h42: modelB[31:0]  = data;
                8'h43: modelB[63:32] = data;
                8'h4A: modelIntEn    = data[0];
                8'h48: if (data[0] && !wasBusy) begin
                    modelRunning  = 1'b1;
                    modelEndCycle = e + MUL_BITS;
                    modelProduct  = 128'(modelA) * 128'(modelB);
                    modelDone     = 1'b0;
                end
                8'h49: if (data[0] && modelDoneEdge != e) begin
                    modelRunning = 1'b0;
                    modelDone    = 1'b0;
                    modelResult  = '0;
                end
                8'h4B: if (data[0] && modelDoneEdge != e) modelDone = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic readBack(input logic [7:0] addr, input string tag);
        ensureGrant();
        M_wr      = 1'b0;
        M_address = addr;
        #1;
        modelSync(cycleCount);
        checkOutput(tag, M_din, expectedRead(addr));
        @(negedge clk);
        M_address = 8'h30;
    endtask

    task automatic checkIrq(input string tag);
        modelSync(cycleCount);
        checkOutput({tag, "_f"}, f_interrupt, modelDone);
        checkOutput({tag, "_m"}, m_interrupt, modelDone & modelIntEn);
    endtask

    task automatic checkRegisters(input string tag);
        for (int a = 8'h40; a <= 8'h4B; a++) begin
            readBack(8'(a), $sformatf("%s@%h", tag, a));
        end
    endtask

    task automatic waitUntil(input int target);
        while (cycleCount < target) @(negedge clk);
    endtask

    task automatic startMultiply(input logic [63:0] a, input logic [63:0] b);
        applyStimulus(8'h40, a[31:0]);
        applyStimulus(8'h41, a[63:32]);
        applyStimulus(8'h42, b[31:0]);
        applyStimulus(8'h43, b[63:32]);
        applyStimulus(8'h48, 32'h1);
    endtask

    task automatic finishRun(input string tag);
        waitUntil(modelEndCycle - 1);
        checkIrq({tag, "_pre"});
        waitUntil(modelEndCycle);
        checkIrq({tag, "_done"});
    endtask

    task automatic applyReset();
        M_req   = 1'b0;
        M_wr    = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        reqOn   = 1'b0;
        modelReset();
    endtask

    function automatic logic [7:0] randomAddr();
        int r;
        r = $urandom_range(0, 255);
        if (r >= 8'h40 && r <= 8'h4B) r = r - 8'h40;
        return 8'(r);
    endfunction

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        M_address = 8'h30;
        M_dout    = 32'h0;
        applyReset();

        checkOutput("rstGrant", M_grant, 1'b0);
        checkOutput("rstDin", M_din, 32'h0);
        checkOutput("rstF", f_interrupt, 1'b0);
        checkOutput("rstM", m_interrupt, 1'b0);

        M_req = 1'b1;
        #1;
        checkOutput("grantBeforeEdge", M_grant, 1'b0);
        @(negedge clk);
        checkOutput("grantRise", M_grant, 1'b1);
        M_req = 1'b0;
        @(negedge clk);
        checkOutput("grantFall", M_grant, 1'b0);
        M_address = 8'h48;
        #1;
        checkOutput("dinNotGranted", M_din, 32'h0);
        reqOn = 1'b0;
        @(negedge clk);

        applyStimulus(8'h00, 32'h12345678);
        applyStimulus(8'h1F, 32'hDEADBEEF);
        readBack(8'h00, "ram00");
        readBack(8'h1F, "ram1F");
        readBack(8'h30, "unmapped30");

        for (int i = 0; i < 32; i++) applyStimulus(8'(i), $urandom);
        for (int n = 0; n < 40; n++) begin
            logic [7:0] ad;
            ad = randomAddr();
            if ($urandom_range(0, 1) == 1) applyStimulus(ad, $urandom);
            else readBack(ad, $sformatf("rnd@%h", ad));
        end
        for (int i = 0; i < 32; i++) readBack(8'(i), $sformatf("ram[%0d]", i));

        startMultiply(64'd5, 64'd4);
        applyStimulus(8'h4A, 32'h1);
        readBack(8'h48, "status5x4Busy");
        finishRun("mul5x4");
        checkRegisters("mul5x4");

        applyStimulus(8'h4B, 32'h1);
        checkIrq("clrDone");
        checkRegisters("clrDone");

        applyStimulus(8'h4A, 32'h0);
        startMultiply(64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF);
        finishRun("fullWidth");
        checkRegisters("fullWidth");

        for (int k = 0; k < 4; k++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            applyStimulus(8'h4A, 32'($urandom_range(0, 1)));
            startMultiply(a, b);
            readBack(8'h48, $sformatf("rnd%0dStatus", k));
            repeat ($urandom_range(2, 20)) @(negedge clk);
            applyStimulus(8'h40, $urandom);
            applyStimulus(8'h43, $urandom);
            applyStimulus(8'h48, 32'h1);
            finishRun($sformatf("rnd%0d", k));
            checkRegisters($sformatf("rnd%0d", k));
        end

        startMultiply({$urandom, $urandom}, {$urandom, $urandom});
        waitUntil(modelEndCycle - 1);
        applyStimulus(8'h4B, 32'h1);
        checkIrq("clrVsDone");
        readBack(8'h48, "clrVsDoneStatus");

        startMultiply({$urandom, $urandom}, {$urandom, $urandom});
        repeat (10) @(negedge clk);
        applyStimulus(8'h49, 32'h1);
        checkIrq("abort");
        checkRegisters("abort");
        repeat (70) @(negedge clk);
        checkIrq("abortLater");

        applyStimulus(8'h4A, 32'h1);
        startMultiply({$urandom, $urandom}, {$urandom, $urandom});
        repeat (10) @(negedge clk);
        reset_n = 1'b1;
        M_req   = 1'b0;
        @(negedge clk);
        checkOutput("midRstGrant", M_grant, 1'b0);
        checkOutput("midRstDin", M_din, 32'h0);
        checkOutput("midRstF", f_interrupt, 1'b0);
        checkOutput("midRstM", m_interrupt, 1'b0);
        reset_n = 1'b0;
        reqOn   = 1'b0;
        modelReset();
        repeat (70) @(negedge clk);
        checkIrq("afterRst");
        checkRegisters("afterRst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
